// File: rtl/chnl_pkg.sv
// Shared definitions for the CHNL receive path.
//   rx_state_e : receive-side transfer state
//   WORD_BITS  : width of one RIFFA length unit (a 32-bit word)
package chnl_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPENING = 2'd1,
        S_OPEN    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/chnl_repack.sv
// Width repacker from wide input words to narrow output words, in units of W-bit chunks.
// Chunk 0 (least significant) of an input word leaves first.
//   IN  : chunks per output word (out_data_o is W*IN bits)
//   OUT : chunks per input word  (in_data_i is W*OUT bits)
//   in_val_i/in_rdy_o/in_data_i    : input stream; in_rdy_o means "input consumed this cycle"
//   out_val_o/out_rdy_i/out_data_o : output stream
// Output words are formed from held chunks followed by the current input word, so an input
// is only taken when it is actually needed; with IN == OUT this is a pure pass-through.
module chnl_repack #(
    parameter int IN  = 1,
    parameter int OUT = 1,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_val_i,
    output logic           in_rdy_o,
    input  logic [W*OUT-1:0] in_data_i,
    output logic           out_val_o,
    input  logic           out_rdy_i,
    output logic [W*IN-1:0] out_data_o
);

    localparam int CAP = IN + OUT;
    localparam int NC  = CAP + OUT + IN;
    localparam int CW  = $clog2(CAP + 1);

    logic [W-1:0]  buf_q [CAP];
    logic [W-1:0]  buf_d [CAP];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  comb_w [NC];
    logic          fire;
    int            c;
    int            n;

    always_comb begin
        c = int'(cnt_q);
        for (int i = 0; i < NC; i++) begin
            comb_w[i] = '0;
        end
        for (int i = 0; i < CAP; i++) begin
            if (i < c) comb_w[i] = buf_q[i];
        end
        for (int i = 0; i < NC; i++) begin
            for (int k = 0; k < OUT; k++) begin
                if (i == c + k) comb_w[i] = in_data_i[k*W +: W];
            end
        end

        out_val_o = (c >= IN) || (in_val_i && (c + OUT >= IN));
        fire      = out_val_o && out_rdy_i;
        // Take the input only when this output word reaches into it, or to accumulate
        // chunks when held + input still cannot form a word.
        in_rdy_o  = in_val_i && ((fire && (c < IN)) || (c + OUT < IN));

        for (int j = 0; j < IN; j++) begin
            out_data_o[j*W +: W] = comb_w[j];
        end
        for (int i = 0; i < CAP; i++) begin
            buf_d[i] = fire ? comb_w[i + IN] : comb_w[i];
        end
        n     = c + (in_rdy_o ? OUT : 0) - (fire ? IN : 0);
        cnt_d = CW'(n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < CAP; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/chnl_rx_fifo_mem.sv
// Synchronous first-word-fall-through FIFO holding whole PCIe beats.
//   clk, rst      : clock, asynchronous active-high reset (flushes pointers)
//   wr_en_i       : write request; accepted when not full, or when full and popping
//   wr_data_i     : write data
//   rd_en_i       : pop request; ignored when empty
//   rd_data_o     : head entry, valid whenever !empty_o (no read latency)
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
module chnl_rx_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = rd_en_i && !empty_o;
    assign do_push = wr_en_i && (!full_o || do_pop);

    assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/chnl_rx_fifo.sv
// Buffered RIFFA CHNL receiver: one host transfer per CHNL_RX open, beats buffered in a
// DEPTH-entry FIFO, repacked to RX_WIDTH words on the o_* stream.
//   clk, rst                  : clock, asynchronous active-high reset
//   o_val/o_rdy/o_data        : consumer stream (RX_WIDTH)
//   o_busy                    : transfer open
//   o_done, o_short           : one-cycle close pulse; o_short if fewer than LEN words arrived
//   o_words                   : words received in the current/last transfer
//   CHNL_RX_CLK               : copy of clk
//   CHNL_RX, CHNL_RX_ACK      : transfer open / one-cycle acknowledge
//   CHNL_RX_LAST, CHNL_RX_OFF : not used
//   CHNL_RX_LEN               : transfer length in 32-bit words
//   CHNL_RX_DATA(_VALID/_REN) : host beat stream
//
// state     | meaning
// S_IDLE    | no transfer; waiting for CHNL_RX
// S_OPENING | CHNL_RX seen; ACK and latch LEN if still high
// S_OPEN    | accepting beats until CHNL_RX drops
module chnl_rx_fifo
    import chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int GCD              = 32,
    parameter int DEPTH            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [RX_WIDTH-1:0]         o_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_short,
    output logic [31:0]                 o_words,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN
);

    localparam int WPB = C_PCI_DATA_WIDTH / WORD_BITS;

    rx_state_e                   state_q, state_d;
    logic [31:0]                 len_q, len_d;
    logic [31:0]                 words_q, words_d;
    logic [32:0]                 words_sum;
    logic                        need;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [C_PCI_DATA_WIDTH-1:0] fifo_rd_data;
    logic                        rp_in_rdy;
    logic                        unused_inputs;

    assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};
    assign CHNL_RX_CLK   = clk;
    assign o_busy        = (state_q == S_OPEN);
    assign o_words       = words_q;

    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        words_d          = words_q;
        CHNL_RX_ACK      = 1'b0;
        CHNL_RX_DATA_REN = 1'b0;
        fifo_push        = 1'b0;
        o_done           = 1'b0;
        o_short          = 1'b0;
        need             = (words_q < len_q);
        // 33 bits so words + WPB can never wrap past len.
        words_sum        = {1'b0, words_q} + 33'(WPB);

        case (state_q)
            S_IDLE: begin
                if (CHNL_RX) state_d = S_OPENING;
            end
            S_OPENING: begin
                if (CHNL_RX) begin
                    CHNL_RX_ACK = 1'b1;
                    len_d       = CHNL_RX_LEN;
                    words_d     = '0;
                    state_d     = S_OPEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                if (CHNL_RX) begin
                    // Beats past LEN are always taken and dropped, even when the FIFO is full.
                    CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID && (!need || !fifo_full);
                    if (CHNL_RX_DATA_REN && need) begin
                        fifo_push = 1'b1;
                        words_d   = (words_sum >= {1'b0, len_q}) ? len_q : words_sum[31:0];
                    end
                end else begin
                    state_d = S_IDLE;
                    o_done  = 1'b1;
                    o_short = need;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
        end
    end

    assign fifo_pop = !fifo_empty && rp_in_rdy;

    chnl_rx_fifo_mem #(
        .WIDTH (C_PCI_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_push),
        .wr_data_i (CHNL_RX_DATA),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    chnl_repack #(
        .IN  (RX_WIDTH / GCD),
        .OUT (C_PCI_DATA_WIDTH / GCD),
        .W   (GCD)
    ) u_repack (
        .clk        (clk),
        .rst        (rst),
        .in_val_i   (!fifo_empty),
        .in_rdy_o   (rp_in_rdy),
        .in_data_i  (fifo_rd_data),
        .out_val_o  (o_val),
        .out_rdy_i  (o_rdy),
        .out_data_o (o_data)
    );

endmodule

// File: tb/tb_chnl_rx_fifo.sv
module tb_chnl_rx_fifo;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         o_rdy = 1'b1;
    logic         host_rx = 1'b0;
    logic         host_valid = 1'b0;
    logic [31:0]  host_len = '0;
    logic [127:0] host_data = '0;

    logic        val32, busy32, done32, short32, ack32, ren32, unused_clk32;
    logic [31:0] data32, words32;
    logic        val128, busy128, done128, short128, ack128, ren128, unused_clk128;
    logic [31:0] data128, words128;

    logic        ren_sel, ack_sel, done_sel, short_sel, val_sel, busy_sel;
    logic [31:0] data_sel, words_sel;

    int          pass_cnt = 0;
    int          tot_cnt = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    logic        short_cap = 1'b0;
    logic [31:0] words_cap = '0;
    logic [31:0] gotq [$];

    always #5 clk = ~clk;

    chnl_rx_fifo #(.C_PCI_DATA_WIDTH(32), .RX_WIDTH(32), .GCD(32), .DEPTH(4)) dut32 (
        .clk(clk), .rst(rst), .o_val(val32), .o_rdy(o_rdy), .o_data(data32),
        .o_busy(busy32), .o_done(done32), .o_short(short32), .o_words(words32),
        .CHNL_RX_CLK(unused_clk32), .CHNL_RX(host_rx & ~sel), .CHNL_RX_ACK(ack32),
        .CHNL_RX_LAST(1'b0), .CHNL_RX_LEN(host_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(host_data[31:0]), .CHNL_RX_DATA_VALID(host_valid & ~sel),
        .CHNL_RX_DATA_REN(ren32)
    );

    chnl_rx_fifo #(.C_PCI_DATA_WIDTH(128), .RX_WIDTH(32), .GCD(32), .DEPTH(4)) dut128 (
        .clk(clk), .rst(rst), .o_val(val128), .o_rdy(o_rdy), .o_data(data128),
        .o_busy(busy128), .o_done(done128), .o_short(short128), .o_words(words128),
        .CHNL_RX_CLK(unused_clk128), .CHNL_RX(host_rx & sel), .CHNL_RX_ACK(ack128),
        .CHNL_RX_LAST(1'b0), .CHNL_RX_LEN(host_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(host_data), .CHNL_RX_DATA_VALID(host_valid & sel),
        .CHNL_RX_DATA_REN(ren128)
    );

    assign ren_sel   = sel ? ren128   : ren32;
    assign ack_sel   = sel ? ack128   : ack32;
    assign done_sel  = sel ? done128  : done32;
    assign short_sel = sel ? short128 : short32;
    assign val_sel   = sel ? val128   : val32;
    assign busy_sel  = sel ? busy128  : busy32;
    assign data_sel  = sel ? data128  : data32;
    assign words_sel = sel ? words128 : words32;

    always @(negedge clk) begin
        if (ack_sel) ack_cnt <= ack_cnt + 1;
        if (done_sel) begin
            done_cnt  <= done_cnt + 1;
            short_cap <= short_sel;
            words_cap <= words_sel;
        end
        if (val_sel && o_rdy) gotq.push_back(data_sel);
    end

    typedef struct {
        int sel;
        int len;
        int nbeats;
        int hold;
        int exp_stall;
        int exp_words;
        int exp_short;
        int exp_out;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] beat_data(input int tag, input int b);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = {8'hC0, 8'(tag), 8'(b), 8'(k)};
        return d;
    endfunction

    function automatic logic [31:0] exp_word(input int s, input int tag, input int idx);
        if (s != 0) return {8'hC0, 8'(tag), 8'(idx / 4), 8'(idx % 4)};
        return {8'hC0, 8'(tag), 8'(idx), 8'h00};
    endfunction

    task automatic run_xfer(input vec_t v, input int tag);
        int b, guard, wpb, exp_w, a0, d0, g0;
        bit fire;
        wpb = (v.sel != 0) ? 4 : 1;
        @(posedge clk); #1;
        sel      = (v.sel != 0);
        a0       = ack_cnt;
        d0       = done_cnt;
        g0       = gotq.size();
        host_len = v.len;
        host_rx  = 1'b1;
        o_rdy    = (v.hold == 0);
        guard    = 0;
        while (ack_cnt == a0 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ack_seen", ack_cnt - a0, 1);
        chk("busy_open", busy_sel, 1);
        host_data  = beat_data(tag, 0);
        host_valid = (v.nbeats > 0);
        b = 0;
        guard = 0;
        while (b < v.nbeats && guard < 200) begin
            @(negedge clk);
            fire = host_valid && ren_sel;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                b++;
                exp_w = (b * wpb < v.len) ? b * wpb : v.len;
                chk("o_words_beat", words_sel, exp_w);
                host_data  = beat_data(tag, b);
                host_valid = (b < v.nbeats);
            end
            if (v.hold != 0 && guard == v.hold) begin
                chk("stall_beats", b, v.exp_stall);
                o_rdy = 1'b1;
            end
        end
        chk("beats_sent", b, v.nbeats);
        host_valid = 1'b0;
        o_rdy      = 1'b1;
        @(posedge clk); #1;
        host_rx = 1'b0;
        @(posedge clk); #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("short_flag", short_cap, v.exp_short);
        chk("words_at_done", words_cap, v.exp_words);
        chk("ack_total", ack_cnt - a0, 1);
        chk("busy_closed", busy_sel, 0);
        chk("o_words_hold", words_sel, v.exp_words);
        guard = 0;
        while ((gotq.size() - g0) < v.exp_out && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("out_count", gotq.size() - g0, v.exp_out);
        for (int i = 0; i < v.exp_out && (g0 + i) < gotq.size(); i++) begin
            chk("o_data", gotq[g0 + i], exp_word(v.sel, tag, i));
        end
    endtask

    initial begin
        int a0, d0, g0;
        vec_t vclean;
        //          sel len nb hold stall words short out
        vecs[0] = '{0,   8,  8,  0,  0,    8,    0,  8};
        vecs[1] = '{0,   8,  8, 15,  4,    8,    0,  8};
        vecs[2] = '{1,   6,  2,  0,  0,    6,    0,  8};
        vecs[3] = '{0,   2,  4,  0,  0,    2,    0,  2};
        vecs[4] = '{0,  10,  3,  0,  0,    3,    1,  3};
        vecs[5] = '{0,   0,  0,  0,  0,    0,    0,  0};
        vecs[6] = '{1,   5,  3,  0,  0,    5,    0,  8};
        vecs[7] = '{1,   8,  1,  0,  0,    4,    1,  4};
        vecs[8] = '{1,  24,  6, 12,  4,   24,    0, 24};
        vclean  = '{0,   4,  4,  0,  0,    4,    0,  4};

        #3;
        chk("rst_val32", val32, 0);
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_short32", short32, 0);
        chk("rst_words32", words32, 0);
        chk("rst_ack32", ack32, 0);
        chk("rst_ren32", ren32, 0);
        chk("rst_val128", val128, 0);
        chk("rst_words128", words128, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_xfer(vecs[i], i + 1);

        // OPENING with CHNL_RX dropped must fall back to IDLE without ACK.
        @(posedge clk); #1;
        sel = 1'b0;
        a0 = ack_cnt;
        host_len = 32'd3;
        host_rx = 1'b1;
        @(posedge clk); #1;
        host_rx = 1'b0;
        @(negedge clk);
        chk("abort_ack", ack32, 0);
        chk("abort_busy", busy32, 0);
        @(posedge clk); #1;
        host_rx = 1'b1;
        @(negedge clk);
        chk("abort_idle_noack", ack32, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reopen_ack", ack32, 1);
        @(posedge clk); #1;
        host_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ack_total", ack_cnt - a0, 1);

        // Reset in the middle of an open transfer with data held in the FIFO.
        @(posedge clk); #1;
        sel = 1'b0;
        o_rdy = 1'b0;
        host_len = 32'd8;
        host_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        host_valid = 1'b1;
        host_data = beat_data(11, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_words", words32, 2);
        chk("pre_rst_val", val32, 1);
        chk("pre_rst_data", data32, exp_word(0, 11, 0));
        d0 = done_cnt;
        g0 = gotq.size();
        rst = 1'b1;
        #1;
        chk("midrst_val", val32, 0);
        chk("midrst_busy", busy32, 0);
        chk("midrst_words", words32, 0);
        chk("midrst_ren", ren32, 0);
        chk("midrst_done", done32, 0);
        @(negedge clk);
        rst = 1'b0;
        host_rx = 1'b0;
        host_valid = 1'b0;
        o_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_val", val32, 0);
        chk("post_rst_no_done", done_cnt - d0, 0);
        chk("post_rst_no_data", gotq.size() - g0, 0);

        run_xfer(vclean, 12);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
